// File: rtl/rca_share_arbiter.sv
// rtl/rca_share_arbiter.sv - round-robin arbiter sharing one ripple-carry adder among R requesters
// Optional macro RCA_SHARE_SUB_EN adds a per-requester sub input (P-Q mode).

module rca #(
    parameter int N = 6
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N:0] c;

    // Ripple the carry bit by bit through N full adders
    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < N; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[N];
    end

endmodule

module rca_share_arbiter #(
    parameter  int N  = 6,
    parameter  int R  = 4,
    localparam int IW = $clog2(R)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [R-1:0]    req,
    input  logic [R*N-1:0]  p_bus,
    input  logic [R*N-1:0]  q_bus,
    input  logic [R-1:0]    cin,
`ifdef RCA_SHARE_SUB_EN
    input  logic [R-1:0]    sub,
`endif
    output logic [R-1:0]    ack,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [N-1:0]    res_sum,
    output logic            res_cout,
    output logic [IW-1:0]   res_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] winner;
    logic          any_req;
    logic          grant;
    logic          res_load;

    logic [N-1:0]  op_p, op_q;
    logic          op_cin;
    logic          op_sub;
    logic [IW-1:0] op_id;

    logic [N-1:0]  add_b;
    logic          add_ci;
    logic [N-1:0]  add_s;
    logic          add_co;

    assign any_req = |req;

    // Pick the first requester at or above the pointer, wrapping around
    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < R; k++) begin
            idx = int'(ptr) + k;
            if (idx >= R) idx = idx - R;
            if (!found && req[idx[IW-1:0]]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state; a grant can happen from IDLE or as the result is drained from HOLD
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        res_load  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant     = 1'b1;
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                res_load  = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    if (any_req) begin
                        grant     = 1'b1;
                        state_nxt = COMPUTE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ack is the grant decode; forced low while reset is held
    assign ack = (grant && rst_n) ? (R'(1) << winner) : '0;

    // Operand latch and round-robin pointer rotation on every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_p   <= '0;
            op_q   <= '0;
            op_cin <= 1'b0;
            op_sub <= 1'b0;
            op_id  <= '0;
            ptr    <= '0;
        end else if (grant) begin
            op_p   <= p_bus[winner*N +: N];
            op_q   <= q_bus[winner*N +: N];
            op_cin <= cin[winner];
`ifdef RCA_SHARE_SUB_EN
            op_sub <= sub[winner];
`else
            op_sub <= 1'b0;
`endif
            op_id  <= winner;
            ptr    <= (winner == IW'(R-1)) ? '0 : winner + 1'b1;
        end
    end

    // Subtraction is P + ~Q + 1; carry-out then means no borrow
    assign add_b  = op_sub ? ~op_q : op_q;
    assign add_ci = op_sub ? 1'b1  : op_cin;

    rca #(.N(N)) u_rca (
        .a  (op_p),
        .b  (add_b),
        .ci (add_ci),
        .s  (add_s),
        .co (add_co)
    );

    // Result registers: load in COMPUTE, drop valid when the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_id    <= '0;
        end else if (res_load) begin
            res_valid <= 1'b1;
            res_sum   <= add_s;
            res_cout  <= add_co;
            res_id    <= op_id;
        end else if (state == HOLD && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
